// File: rtl/result_reader.sv
// Readback engine: walks an SRAM address range, reads each 64-bit result word
// from the A/B SRAM pair and streams it out through a 2-entry valid/ready FIFO.
module result_reader #(
    parameter int ADDR_W        = 8,
    parameter int MEM_WORD_SIZE = 64,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    output logic                     read,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [31:0]              r_data_a,
    input  logic [31:0]              r_data_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MEM_WORD_SIZE-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RUN   | issuing reads from curr_addr up to last_addr
    // S_DRAIN | all reads issued, waiting for in-flight data and FIFO to empty
    // S_DONE  | one-cycle done (and err on an inverted range)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        curr_addr;
    logic [ADDR_W-1:0]        last_addr;
    logic [ADDR_W-1:0]        r_addr_q;
    logic                     err_q;
    logic                     inflight;
    logic                     inflight_last;
    logic [MEM_WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
    logic                     fifo_last [FIFO_DEPTH];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               fifo_count;
    logic                     push;
    logic                     pop;
    logic                     issue;
    logic                     issue_last;
    logic [2:0]               credit_use;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Issue is decoded combinationally so a pop in this cycle frees a slot
    // immediately; this is what sustains one word per cycle.
    assign credit_use = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == S_RUN) && (credit_use < 3'(FIFO_DEPTH));
    assign issue_last = issue && (curr_addr == last_addr);

    assign read     = ~issue;
    assign r_addr   = issue ? curr_addr : r_addr_q;
    assign out_data = fifo_data[rd_ptr];
    assign out_last = fifo_last[rd_ptr];
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign err      = done & err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state         <= S_IDLE;
            curr_addr     <= '0;
            last_addr     <= '0;
            r_addr_q      <= '0;
            err_q         <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        curr_addr <= start_addr;
                        last_addr <= end_addr;
                        if (end_addr < start_addr) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Compared before the increment, so an end at the top of
                    // the address space never wraps back to zero.
                    if (issue_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_count == 2'd0 && !inflight) state <= S_DONE;
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                r_addr_q  <= curr_addr;
                curr_addr <= curr_addr + ADDR_W'(1);
            end
            inflight      <= issue;
            inflight_last <= issue_last;

            if (push) begin
                fifo_data[wr_ptr] <= {r_data_b, r_data_a};
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        (push && !pop) |-> (fifo_count < 2'(FIFO_DEPTH)));

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: SRAM model, scoreboard of expected words per range,
// table of directed ranges, a reset-abort sequence and randomized ranges.
module tb_result_reader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [7:0]  end_addr = '0;
    logic        read;
    logic [7:0]  r_addr;
    logic [31:0] r_data_a = '0;
    logic [31:0] r_data_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    result_reader #(.ADDR_W(8), .MEM_WORD_SIZE(64), .FIFO_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start),
        .start_addr(start_addr), .end_addr(end_addr),
        .read(read), .r_addr(r_addr),
        .r_data_a(r_data_a), .r_data_b(r_data_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        int         mode;
        int         exp_words;
        logic       exp_err;
    } vec_t;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    beat_t       exp_q[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          pat = 0;
    bit          run_active = 0;
    int          exp_total = 0;
    int          issued = 0;
    int          accepted = 0;
    int          start_cyc = 0;
    int          first_read = -1;
    int          first_valid = -1;
    int          last_beat_cyc = 0;
    logic [7:0]  next_rd = '0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Synchronous SRAM pair: data appears the cycle after read=0
    always @(posedge clk_i) begin
        if (!read) begin
            r_data_a <= mem_a[r_addr];
            r_data_b <= mem_b[r_addr];
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (pat % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        pat++;
    end

    // Scoreboard / protocol monitor
    always @(negedge clk_i) begin
        bit    pop_now;
        beat_t w;
        if (run_active) begin
            pop_now = out_valid && out_ready;
            check("err_only_with_done", 64'(err & ~done), 64'd0);
            if (!read) begin
                if (first_read < 0) first_read = cyc;
                check("read_within_range", 64'(issued < exp_total), 64'd1);
                check("r_addr_order", 64'(r_addr), 64'(next_rd));
                check("outstanding_le2", 64'((issued + 1 - accepted - int'(pop_now)) <= 2), 64'd1);
                issued++;
                next_rd++;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_valid && !prev_ready) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_last_stable", 64'(out_last), 64'(prev_last));
                end
            end
            if (pop_now) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.d);
                    check("out_last", 64'(out_last), 64'(w.l));
                end
                if (ready_mode == 0 && accepted > 0)
                    check("throughput", 64'(cyc), 64'(last_beat_cyc + 1));
                last_beat_cyc = cyc;
                accepted++;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Reference: the run yields {B[a],A[a]} for a = s..e, last on a == e
    task automatic start_run(input logic [7:0] s, input logic [7:0] e);
        beat_t b;
        exp_q.delete();
        exp_total = 0;
        for (int a = int'(s); a <= int'(e); a++) begin
            b.d = {mem_b[a], mem_a[a]};
            b.l = (a == int'(e));
            exp_q.push_back(b);
            exp_total++;
        end
        issued = 0;
        accepted = 0;
        next_rd = s;
        first_read = -1;
        first_valid = -1;
        prev_valid = 0;
        @(posedge clk_i);
        #1;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        start_cyc  = cyc;
        run_active = 1;
        @(posedge clk_i);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input vec_t v);
        bit got_done = 0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            @(negedge clk_i);
            if (done) begin
                got_done = 1;
                check("err_at_done", 64'(err), 64'(v.exp_err));
                check("words_left_at_done", 64'(exp_q.size()), 64'd0);
            end
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("word_count", 64'(accepted), 64'(v.exp_words));
        check("read_count", 64'(issued), 64'(v.exp_words));
        if (v.exp_words > 0) begin
            check("first_read_latency", 64'(first_read - start_cyc), 64'd1);
            check("first_valid_latency", 64'(first_valid - start_cyc), 64'd3);
            check("r_addr_hold", 64'(r_addr), 64'(v.e));
        end
        @(negedge clk_i);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        run_active = 0;
    endtask

    task automatic run_vec(input vec_t v);
        ready_mode = v.mode;
        pat = 0;
        start_run(v.s, v.e);
        finish_run(v);
    endtask

    vec_t vecs [7];
    vec_t rv;

    initial begin
        vecs[0] = '{s: 8'd4,   e: 8'd7,   mode: 0, exp_words: 4,  exp_err: 1'b0};
        vecs[1] = '{s: 8'd4,   e: 8'd7,   mode: 1, exp_words: 4,  exp_err: 1'b0};
        vecs[2] = '{s: 8'd9,   e: 8'd9,   mode: 0, exp_words: 1,  exp_err: 1'b0};
        vecs[3] = '{s: 8'd5,   e: 8'd3,   mode: 0, exp_words: 0,  exp_err: 1'b1};
        vecs[4] = '{s: 8'd252, e: 8'd255, mode: 0, exp_words: 4,  exp_err: 1'b0};
        vecs[5] = '{s: 8'd0,   e: 8'd0,   mode: 2, exp_words: 1,  exp_err: 1'b0};
        vecs[6] = '{s: 8'd10,  e: 8'd40,  mode: 2, exp_words: 31, exp_err: 1'b0};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = 32'h100 + 32'(i);
        end

        // Reset state
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_read", 64'(read), 64'd1);
        check("rst_r_addr", 64'(r_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset mid-run, with a second start pulsed while busy
        ready_mode = 1;
        pat = 0;
        start_run(8'd4, 8'd7);
        start_addr = 8'd0;
        end_addr   = 8'd0;
        start      = 1'b1;
        @(posedge clk_i);
        #1 start = 1'b0;
        for (int c = 0; c < 100 && accepted < 2; c++) @(negedge clk_i);
        check("two_beats_before_reset", 64'(accepted), 64'd2);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run_active = 0;
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_read", 64'(read), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_r_addr", 64'(r_addr), 64'd0);
        begin
            bit saw = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk_i);
                if (done || out_valid || !read) saw = 1;
            end
            check("quiet_after_abort", 64'(saw), 64'd0);
        end
        run_vec(vecs[0]);

        // Randomized ranges and memory contents
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        for (int k = 0; k < 24; k++) begin
            int len;
            rv.s = 8'($urandom_range(0, 255));
            if (k % 6 == 5 && rv.s > 0) begin
                rv.e = 8'($urandom_range(0, int'(rv.s) - 1));
            end else begin
                len = $urandom_range(0, 10);
                rv.e = (int'(rv.s) + len > 255) ? 8'd255 : 8'(int'(rv.s) + len);
            end
            rv.mode      = $urandom_range(0, 2);
            rv.exp_err   = (rv.e < rv.s);
            rv.exp_words = rv.exp_err ? 0 : int'(rv.e) - int'(rv.s) + 1;
            run_vec(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
